bsg_comm_link_pkt_demux: RTL and testbench
==========================================

BSG_COMM_LINK_PKT_DEMUX -- requirements
Module: bsg_comm_link_pkt_demux

Interface
REQ-001 SHALL have parameter width_p, default 80, fused core word width, equal to comm-link core width.
REQ-002 SHALL have parameter num_out_p, default 4, number of destination ports, range 2..16.
REQ-003 SHALL have parameter len_width_p, default 4, width of the header body-length field.
REQ-004 SHALL have parameter drop_cnt_width_p, default 16, width of the drop counter.
REQ-005 SHALL have derived id_width = ceil(log2(num_out_p)); width_p SHALL be >= id_width+len_width_p.
REQ-006 clk_i  input  1  sole clock; all logic rising-edge.
REQ-007 reset_i  input  1  reset, synchronous and active-high.
REQ-008 valid_i  input  1  fused word valid, fed from comm-link core_valid_o.
REQ-009 data_i  input  width_p  fused word.
REQ-010 yumi_o  output  1  word consumed this cycle, driving comm-link core_yumi_i; SHALL be asserted only when valid_i=1.
REQ-011 v_o  output  num_out_p  per-port valid, one-hot or zero.
REQ-012 data_o  output  width_p  word shared by all ports.
REQ-013 last_o  output  1  data_o is the final beat of its packet.
REQ-014 ready_i  input  num_out_p  per-port ready; a beat transfers on v_o[k]&ready_i[k].
REQ-015 drop_count_o  output  drop_cnt_width_p  count of dropped packets, saturating.

Function
REQ-016 Header word: dest = data_i[id_width-1:0]; len = data_i[id_width+:len_width_p] = body beats following, 0..2^len_width_p-1.
REQ-017 FSM states: IDLE (expect header), FWD (forward body), DROP (discard body).
REQ-018 In IDLE, a header with dest<num_out_p SHALL be forwarded as beat 0 to port dest; next state FWD if len>0, else stay IDLE.
REQ-019 In IDLE, a header with dest>=num_out_p SHALL be consumed at once, not forwarded, and increment drop_count_o. Next state DROP if len>0, else IDLE.
REQ-020 On accepting a header, remaining-beat counter SHALL load len; each accepted body beat SHALL decrement it; the beat accepted with counter==1 SHALL return the FSM to IDLE.
REQ-021 The destination latched at the header SHALL route all body beats of the packet.
REQ-022 Output stage SHALL be a 2-entry buffer holding {data, dest, last}. Latency: a word accepted at cycle t SHALL be visible on v_o/data_o at t+1 at the earliest.
REQ-023 yumi_o in IDLE and FWD SHALL equal valid_i & buffer-not-full.
REQ-024 Buffer-not-full SHALL be registered; a full buffer SHALL NOT accept in the cycle it dequeues.
REQ-025 yumi_o in DROP, and for an invalid header, SHALL equal valid_i, independent of ready_i.
REQ-026 v_o[k] SHALL equal buffer_valid & (head.dest==k). A head beat SHALL dequeue only on ready_i[head.dest]; ready_i of other ports SHALL be ignored.
REQ-027 last_o SHALL be 1 for a len=0 header and for the final body beat.
REQ-028 drop_count_o SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 Order SHALL be preserved: no beat of packet n+1 SHALL leave before the last beat of packet n.

Reset
REQ-030 While reset_i=1: FSM=IDLE, counter=0, buffer empty, v_o=0, yumi_o=0, last_o=0, drop_count_o=0. data_o SHALL be don't-care.
REQ-031 Reset mid-packet SHALL discard buffered and partial-packet state. The first word after reset SHALL be treated as a header.

Structure
REQ-032 The header field offsets and the FSM state enum SHALL reside in a shared package, bsg_comm_link_pkt_pkg.
REQ-033 The output buffer SHALL be an instance of bsg_two_fifo, width width_p+id_width+1.
REQ-034 Target size: 120-400 RTL lines.

Verification (width_p=80, num_out_p=4, len_width_p=4)
REQ-035 Reset; header dest=2 len=0, all ready=1 -> v_o=4'b0100, last_o=1 at t+1; drop_count_o=0.
REQ-036 Header dest=1 len=3 plus 3 body words, ready_i[1] toggling 1/0 -> exactly 4 beats on port 1 in order; last_o only on beat 4; no other v_o bit set.
REQ-037 num_out_p=3, header dest=3 len=2, ready_i=0 -> 3 words consumed in 3 cycles; v_o stays 0; drop_count_o=1.
REQ-038 ready_i=0 with stream valid -> yumi_o low after 2 words; ready_i[dest]=1 -> one dequeue per cycle, with no accept in the same cycle the full buffer drains.
REQ-039 reset_i pulsed after 1 of 5 body beats -> outputs zero next cycle; next word is routed as a header.
REQ-040 Force drop_count_o=16'hFFFF via 65535+ bad headers -> stays FFFF on next drop.

Source files
------------

// File: rtl/bsg_comm_link_pkt_pkg.sv
// Shared definitions for the comm-link packet demultiplexer: header field
// placement and the receive FSM state encoding.
package bsg_comm_link_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // next word is a header
        FWD  = 2'd1,   // forwarding body beats to the latched port
        DROP = 2'd2    // discarding body beats of a misaddressed packet
    } pkt_state_e;

    // Destination id sits at the bottom of the header word.
    localparam int hdr_dest_lsb_gp = 0;

    // Body-length field starts immediately above the destination id.
    function automatic int hdr_len_lsb(input int id_width);
        return hdr_dest_lsb_gp + id_width;
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with registered full/empty flags. ready_o comes straight from
// a flop, so a full FIFO cannot accept in the same cycle it is being drained.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [1:0][width_p-1:0] mem_q;
    logic                    rd_ptr_q, wr_ptr_q;
    logic                    empty_q, full_q;
    logic                    enq, deq;

    assign ready_o = ~full_q;
    assign v_o     = ~empty_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i & ~full_q;
    assign deq     = yumi_i & ~empty_q;

    // Pointer and occupancy flag update; simultaneous enq/deq leaves flags alone.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (enq) wr_ptr_q <= ~wr_ptr_q;
            if (deq) rd_ptr_q <= ~rd_ptr_q;
            if (enq & ~deq) begin
                empty_q <= 1'b0;
                full_q  <= (~wr_ptr_q == rd_ptr_q);
            end else if (deq & ~enq) begin
                full_q  <= 1'b0;
                empty_q <= (~rd_ptr_q == wr_ptr_q);
            end
        end
    end

    // Storage needs no reset; occupancy flags qualify it.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_comm_link_pkt_demux.sv
// Splits the fused comm-link word stream into per-destination packet streams.
// A header word names the port and the body length; misaddressed packets are
// swallowed whole and counted. Output goes through a 2-entry buffer.
module bsg_comm_link_pkt_demux
    import bsg_comm_link_pkt_pkg::*;
#(
    parameter int width_p          = 80,
    parameter int num_out_p        = 4,
    parameter int len_width_p      = 4,
    parameter int drop_cnt_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    input  logic [width_p-1:0]          data_i,
    output logic                        yumi_o,
    output logic [num_out_p-1:0]        v_o,
    output logic [width_p-1:0]          data_o,
    output logic                        last_o,
    input  logic [num_out_p-1:0]        ready_i,
    output logic [drop_cnt_width_p-1:0] drop_count_o
);

    localparam int id_width_lp   = $clog2(num_out_p);
    localparam int len_lsb_lp    = hdr_len_lsb(id_width_lp);
    localparam int fifo_width_lp = width_p + id_width_lp + 1;

    typedef logic [id_width_lp-1:0] id_t;
    typedef logic [id_width_lp:0]   id_ext_t;
    typedef logic [len_width_p-1:0] len_t;

    localparam id_ext_t num_out_lp = id_ext_t'(num_out_p);

    pkt_state_e                  state_q;
    len_t                        cnt_q;
    id_t                         dest_q;
    logic [drop_cnt_width_p-1:0] drop_cnt_q;

    id_t                         hdr_dest;
    len_t                        hdr_len;
    logic                        hdr_ok;
    logic                        fwd_v, yumi, enq_last;
    id_t                         enq_dest, head_dest;
    logic                        head_last;
    logic                        fifo_ready, fifo_v;
    logic [fifo_width_lp-1:0]    fifo_din, fifo_dout;

    assign hdr_dest = data_i[hdr_dest_lsb_gp +: id_width_lp];
    assign hdr_len  = data_i[len_lsb_lp +: len_width_p];
    assign hdr_ok   = {1'b0, hdr_dest} < num_out_lp;

    // Decide whether the current word is forwarded or discarded and when it is taken.
    always_comb begin
        fwd_v    = 1'b0;
        yumi     = 1'b0;
        enq_dest = dest_q;
        enq_last = (cnt_q == len_t'(1));
        unique case (state_q)
            IDLE: begin
                enq_dest = hdr_dest;
                enq_last = (hdr_len == '0);
                if (hdr_ok) begin
                    fwd_v = valid_i;
                    yumi  = valid_i & fifo_ready;
                end else begin
                    yumi  = valid_i;
                end
            end
            FWD: begin
                fwd_v = valid_i;
                yumi  = valid_i & fifo_ready;
            end
            default: yumi = valid_i;
        endcase
        if (reset_i) begin
            fwd_v = 1'b0;
            yumi  = 1'b0;
        end
    end

    assign yumi_o   = yumi;
    assign fifo_din = {enq_last, enq_dest, data_i};

    // Packet framing FSM: latch dest/length at the header, count down the body.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dest_q     <= '0;
            drop_cnt_q <= '0;
        end else if (yumi) begin
            unique case (state_q)
                IDLE: begin
                    cnt_q  <= hdr_len;
                    dest_q <= hdr_dest;
                    if (!hdr_ok && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
                    if (hdr_len != '0) state_q <= hdr_ok ? FWD : DROP;
                end
                default: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == len_t'(1)) state_q <= IDLE;
                end
            endcase
        end
    end

    assign drop_count_o = drop_cnt_q;

    bsg_two_fifo #(.width_p(fifo_width_lp)) u_obuf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fwd_v),
        .data_i  (fifo_din),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (fifo_dout),
        .yumi_i  (|(v_o & ready_i))
    );

    assign {head_last, head_dest, data_o} = fifo_dout;

    // Steer the buffer head to its port; only that port's ready can drain it.
    always_comb begin
        v_o = '0;
        for (int k = 0; k < num_out_p; k++)
            v_o[k] = fifo_v & ~reset_i & (head_dest == id_t'(k));
    end

    assign last_o = fifo_v & head_last & ~reset_i;

endmodule

// File: tb/tb_bsg_comm_link_pkt_demux.sv
// Randomized bench for the packet demux (3 ports, so dest 3 is a bad address).
// A queue-based packet model predicts buffer contents, acceptance and drops.
module tb_bsg_comm_link_pkt_demux;

    localparam int W = 80, N = 3, L = 4, D = 16;

    logic         clk = 1'b0, reset = 1'b1, valid = 1'b0;
    logic [W-1:0] data = '0;
    logic         yumi, last;
    logic [N-1:0] v, ready = '0;
    logic [W-1:0] dout;
    logic [D-1:0] dcnt;

    always #5 clk = ~clk;

    bsg_comm_link_pkt_demux #(.width_p(W), .num_out_p(N), .len_width_p(L), .drop_cnt_width_p(D)) dut (
        .clk_i(clk), .reset_i(reset), .valid_i(valid), .data_i(data), .yumi_o(yumi),
        .v_o(v), .data_o(dout), .last_o(last), .ready_i(ready), .drop_count_o(dcnt)
    );

    typedef struct { logic [W-1:0] data; int port; bit last; } beat_t;

    beat_t        mbuf[$];     // words that should be sitting in the output buffer
    logic [W-1:0] pend[$];     // stimulus words not yet consumed
    int m_rem = 0, m_dest = 0, m_drops = 0;
    bit m_drop = 0;
    int n_tests = 0, n_fail = 0;
    int cyc = 0, accepted = 0, rdy_mode = 0, vprob = 100;
    int xfers[N];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input int d, input int len);
        logic [W-1:0] w;
        w = W'({$urandom, $urandom, $urandom});
        if (d >= 0) begin
            w[1:0] = 2'(d);
            w[5:2] = 4'(len);
        end
        return w;
    endfunction

    task automatic push_pkt(input int d, input int len);
        pend.push_back(mk_word(d, len));
        for (int i = 0; i < len; i++) pend.push_back(mk_word(-1, 0));
    endtask

    function automatic void model_accept(input logic [W-1:0] w);
        int d, len;
        if (m_rem == 0) begin
            d   = int'(w[1:0]);
            len = int'(w[5:2]);
            if (d < N) begin
                mbuf.push_back('{w, d, len == 0});
                m_drop = 0;
                m_dest = d;
            end else begin
                m_drop = 1;
                if (m_drops < 65535) m_drops++;
            end
            m_rem = len;
        end else begin
            m_rem--;
            if (!m_drop) mbuf.push_back('{w, m_dest, m_rem == 0});
        end
    endfunction

    function automatic void model_clear();
        mbuf.delete();
        pend.delete();
        m_rem = 0; m_drop = 0; m_drops = 0;
    endfunction

    // One clock: drive, check at negedge, advance model, then take the edge.
    task automatic step();
        logic [N-1:0] exp_v;
        bit exp_y, xfer;
        case (rdy_mode)
            0: ready = '1;
            1: ready = '0;
            2: ready = (cyc % 2 == 0) ? '1 : '0;
            default: ready = N'($urandom);
        endcase
        valid = (pend.size() > 0) && ($urandom_range(99) < vprob);
        data  = valid ? pend[0] : mk_word(-1, 0);
        @(negedge clk);
        exp_v = '0;
        if (mbuf.size() > 0) exp_v[mbuf[0].port] = 1'b1;
        check("v_o", W'(v), W'(exp_v));
        if (mbuf.size() > 0) begin
            check("data_o", dout, mbuf[0].data);
            check("last_o", W'(last), W'(mbuf[0].last));
        end else begin
            check("last_idle", W'(last), W'(0));
        end
        if (!valid) exp_y = 0;
        else if (m_rem == 0) exp_y = (int'(data[1:0]) >= N) ? 1 : (mbuf.size() < 2);
        else exp_y = m_drop ? 1 : (mbuf.size() < 2);
        check("yumi_o", W'(yumi), W'(exp_y));
        check("drop_count", W'(dcnt), W'(m_drops));
        xfer = (mbuf.size() > 0) && ready[mbuf[0].port];
        if (xfer) begin
            xfers[mbuf[0].port]++;
            void'(mbuf.pop_front());
        end
        if (yumi) begin
            accepted++;
            void'(pend.pop_front());
            model_accept(data);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_empty(input int budget);
        int c;
        c = 0;
        while ((pend.size() > 0 || mbuf.size() > 0) && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) check("timeout", W'(1), W'(0));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        valid = 1'b1;
        ready = '1;
        @(negedge clk);
        check("rst_v_o", W'(v), W'(0));
        check("rst_yumi", W'(yumi), W'(0));
        check("rst_last", W'(last), W'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        model_clear();
    endtask

    initial begin
        int c, n;
        for (int i = 0; i < N; i++) xfers[i] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        check("rst_drop", W'(dcnt), W'(0));
        @(posedge clk);
        #1;

        // Single-beat packet to port 2
        rdy_mode = 0; vprob = 100;
        push_pkt(2, 0);
        run_until_empty(20);
        check("p2_beats", W'(xfers[2]), W'(1));

        // Four-beat packet to port 1 with toggling ready
        rdy_mode = 2;
        push_pkt(1, 3);
        run_until_empty(40);
        check("p1_beats", W'(xfers[1]), W'(4));
        check("p0_none", W'(xfers[0]), W'(0));

        // Misaddressed packet with ready low: swallowed in three cycles
        rdy_mode = 1;
        c = cyc;
        push_pkt(3, 2);
        run_until_empty(20);
        check("drop_cycles", W'(cyc - c), W'(3));
        check("drop_one", W'(dcnt), W'(1));

        // Backpressure: buffer takes two words then stalls, then drains
        accepted = 0;
        push_pkt(0, 5);
        repeat (6) step();
        check("bp_accepted", W'(accepted), W'(2));
        rdy_mode = 0;
        run_until_empty(40);
        check("p0_beats", W'(xfers[0]), W'(6));

        // Random traffic
        rdy_mode = 3; vprob = 70;
        for (int p = 0; p < 300; p++)
            push_pkt($urandom_range(3), ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(2));
        run_until_empty(20000);

        // Reset in the middle of a packet; next word must be a header
        rdy_mode = 0; vprob = 100;
        accepted = 0;
        push_pkt(0, 5);
        c = 0;
        while (accepted < 2 && c < 20) begin
            step();
            c++;
        end
        check("mid_accepted", W'(accepted), W'(2));
        pulse_reset();
        n = xfers[2];
        push_pkt(2, 0);
        run_until_empty(20);
        check("post_rst_hdr", W'(xfers[2] - n), W'(1));

        // Drop counter saturation
        for (int i = 0; i < 65540; i++) pend.push_back(mk_word(3, 0));
        run_until_empty(70000);
        check("sat_ffff", W'(dcnt), W'(16'hFFFF));
        push_pkt(3, 0);
        run_until_empty(10);
        check("sat_hold", W'(dcnt), W'(16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
